// File: rtl/escalonador_poli.sv
// escalonador_poli: round-robin two-port arbiter and Horner sequencer for the operativo datapath.
// Define ESCALONADOR_TIMEOUT_EN to bound WAIT to TIMEOUT cycles and flag erro on expiry.
module escalonador_poli #(
  parameter int W       = 16,
  parameter int TIMEOUT = 15
) (
  input  logic         ck,
  input  logic         rst,
  input  logic [1:0]   req,
  output logic [1:0]   gnt,
  output logic [1:0]   res_vld,
  output logic [W-1:0] res_data,
  output logic         erro,
  output logic         busy,
  output logic         lx,
  output logic [1:0]   m0,
  output logic [1:0]   m1,
  output logic [1:0]   m2,
  output logic         h,
  output logic         ls,
  output logic         lh,
  input  logic         done,
  input  logic [W-1:0] Resultado
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL1, S_ADD1, S_MUL2, S_ADD2, S_WAIT, S_RESP
  } state_t;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] res_vld;
    logic       busy;
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       ls;
    logic       lh;
  } ctrl_t;

  state_t state, state_nxt;
  logic   g, g_nxt;
  logic   ptr;
  logic   timeout_hit;
  ctrl_t  ctrl_q;

  // Control word for a given state/bank; registered from the next state so outputs are flops.
  function automatic ctrl_t decode(input state_t s, input logic sel);
    ctrl_t c;
    c = '0;
    c.busy = (s != S_IDLE);
    if (s != S_IDLE) c.m2 = {1'b0, sel};
    case (s)
      S_LOAD: begin
        c.lx  = 1'b1;
        c.gnt = sel ? 2'b10 : 2'b01;
      end
      S_MUL1: begin c.m0 = 2'b00; c.m1 = 2'b00; c.h = 1'b1; c.lh = 1'b1; end
      S_ADD1: begin c.m0 = 2'b01; c.m1 = 2'b01; c.h = 1'b0; c.lh = 1'b1; end
      S_MUL2: begin c.m0 = 2'b01; c.m1 = 2'b00; c.h = 1'b1; c.lh = 1'b1; end
      S_ADD2: begin c.m0 = 2'b01; c.m1 = 2'b10; c.h = 1'b0; c.ls = 1'b1; end
      S_RESP: c.res_vld = sel ? 2'b10 : 2'b01;
      default: ;
    endcase
    return c;
  endfunction

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    case (state)
      S_IDLE: if (req != 2'b00) begin
        state_nxt = S_LOAD;
        g_nxt     = (req == 2'b11) ? ptr : req[1];
      end
      S_LOAD: state_nxt = S_MUL1;
      S_MUL1: state_nxt = S_ADD1;
      S_ADD1: state_nxt = S_MUL2;
      S_MUL2: state_nxt = S_ADD2;
      S_ADD2: state_nxt = S_WAIT;
      S_WAIT: if (done || timeout_hit) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset clears every flop here.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      g        <= 1'b0;
      ptr      <= 1'b0;
      ctrl_q   <= '0;
      res_data <= '0;
    end else begin
      state  <= state_nxt;
      g      <= g_nxt;
      ctrl_q <= decode(state_nxt, g_nxt);
      if (state == S_RESP) ptr <= ~g;
      if (state == S_WAIT && done) res_data <= Resultado;
      else if (timeout_hit)        res_data <= '0;
    end
  end

`ifdef ESCALONADOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          erro_q;

  assign timeout_hit = (state == S_WAIT) && !done && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      erro_q   <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == S_IDLE && state_nxt == S_LOAD) erro_q <= 1'b0;
      else if (timeout_hit)                       erro_q <= 1'b1;
    end
  end

  assign erro = erro_q;
`else
  // WAIT never expires; the comparison only keeps TIMEOUT referenced and is constant false.
  assign timeout_hit = (TIMEOUT < 0);
  assign erro        = 1'b0;
`endif

  assign gnt     = ctrl_q.gnt;
  assign res_vld = ctrl_q.res_vld;
  assign busy    = ctrl_q.busy;
  assign lx      = ctrl_q.lx;
  assign m0      = ctrl_q.m0;
  assign m1      = ctrl_q.m1;
  assign m2      = ctrl_q.m2;
  assign h       = ctrl_q.h;
  assign ls      = ctrl_q.ls;
  assign lh      = ctrl_q.lh;

endmodule

// File: tb/tb_escalonador_poli.sv
// Self-checking bench for escalonador_poli with a small behavioural operativo datapath.
// Honours ESCALONADOR_TIMEOUT_EN for the done-held-low sequence.
module tb_escalonador_poli;
  localparam int W = 16;

  logic         ck = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [1:0]   gnt, res_vld, m0, m1, m2;
  logic [W-1:0] res_data, Resultado;
  logic         erro, busy, lx, h, ls, lh, done;

  escalonador_poli #(.W(W), .TIMEOUT(15)) dut (
    .ck(ck), .rst(rst), .req(req), .gnt(gnt), .res_vld(res_vld), .res_data(res_data),
    .erro(erro), .busy(busy), .lx(lx), .m0(m0), .m1(m1), .m2(m2), .h(h), .ls(ls), .lh(lh),
    .done(done), .Resultado(Resultado)
  );

  always #5 ck = ~ck;

  // Behavioural datapath: operand banks, X/H/S registers, done one cycle after ls.
  logic [W-1:0] bank_a[2], bank_b[2], bank_c[2], bank_x[2];
  logic [W-1:0] mx, mh, ms, op1, op2, alu;
  logic         done_q;
  logic         done_en = 1'b1;
  logic         done_force = 1'b0;

  always_comb begin
    op1 = '0;
    op2 = '0;
    case (m0)
      2'b00: op1 = bank_a[m2[0]];
      2'b01: op1 = mh;
      2'b10: op1 = ms;
      default: op1 = '0;
    endcase
    case (m1)
      2'b00: op2 = mx;
      2'b01: op2 = bank_b[m2[0]];
      2'b10: op2 = bank_c[m2[0]];
      default: op2 = '0;
    endcase
    alu = h ? W'(op1 * op2) : W'(op1 + op2);
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      mx <= '0; mh <= '0; ms <= '0; done_q <= 1'b0;
    end else begin
      if (lx) mx <= bank_x[m2[0]];
      if (lh) mh <= alu;
      if (ls) ms <= alu;
      done_q <= ls & done_en;
    end
  end

  assign done      = done_q | done_force;
  assign Resultado = ms;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]   req;
    logic [1:0]   exp_gnt;
    logic [W-1:0] a, b, c, x;
    logic [W-1:0] exp_res;
  } vec_t;

  vec_t       vecs[10];
  logic [8:0] exp_word[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] word_now();
    return {lx, m0, m1, h, ls, lh};
  endfunction

  function automatic logic [31:0] outs_now();
    return {gnt, res_vld, res_data, erro, busy, lx, m0, m1, m2, h, ls, lh};
  endfunction

  // One full transaction from an idle cycle; req bits other than the granted one are left set.
  task automatic run_txn(input vec_t v);
    int cyc;
    bank_a[v.exp_gnt[1]] = v.a;
    bank_b[v.exp_gnt[1]] = v.b;
    bank_c[v.exp_gnt[1]] = v.c;
    bank_x[v.exp_gnt[1]] = v.x;
    @(negedge ck);
    check("idle_busy", busy, 1'b0);
    req = req | v.req;
    cyc = 0;
    do begin @(negedge ck); cyc++; end while (gnt == 2'b00 && cyc < 10);
    check("gnt_latency", cyc, 1);
    check("gnt", gnt, v.exp_gnt);
    check("load_busy", busy, 1'b1);
    req = req & ~v.exp_gnt;
    for (int s = 0; s < 6; s++) begin
      if (s > 0) @(negedge ck);
      check("ctrl_word", word_now(), exp_word[s]);
      check("m2_bank", m2, {1'b0, v.exp_gnt[1]});
      check("load_excl", ($countones({lx, lh, ls}) > 1), 1'b0);
    end
    cyc = 0;
    do begin @(negedge ck); cyc++; end while (res_vld == 2'b00 && cyc < 40);
    check("vld_latency", cyc, 1);
    check("res_vld", res_vld, v.exp_gnt);
    check("res_data", res_data, v.exp_res);
    check("erro", erro, 1'b0);
  endtask

  initial begin
    int   cyc;
    logic seen;
    vec_t v;

    exp_word[0] = 9'b1_00_00_0_0_0;  // LOAD
    exp_word[1] = 9'b0_00_00_1_0_1;  // MUL1
    exp_word[2] = 9'b0_01_01_0_0_1;  // ADD1
    exp_word[3] = 9'b0_01_00_1_0_1;  // MUL2
    exp_word[4] = 9'b0_01_10_0_1_0;  // ADD2
    exp_word[5] = 9'b0_00_00_0_0_0;  // WAIT

    vecs[0] = '{req: 2'b11, exp_gnt: 2'b01, a: 16'd2,    b: 16'd3,    c: 16'd4,    x: 16'd5,    exp_res: 16'h0045};
    vecs[1] = '{req: 2'b00, exp_gnt: 2'b10, a: 16'd1,    b: 16'd1,    c: 16'd1,    x: 16'd2,    exp_res: 16'd7};
    vecs[2] = '{req: 2'b11, exp_gnt: 2'b01, a: 16'h0100, b: 16'h0000, c: 16'h0001, x: 16'h0100, exp_res: 16'h0001};
    vecs[3] = '{req: 2'b00, exp_gnt: 2'b10, a: 16'd3,    b: 16'hFFFF, c: 16'd2,    x: 16'd0,    exp_res: 16'd2};
    vecs[4] = '{req: 2'b01, exp_gnt: 2'b01, a: 16'd0,    b: 16'd7,    c: 16'h0010, x: 16'd3,    exp_res: 16'd37};
    vecs[5] = '{req: 2'b01, exp_gnt: 2'b01, a: 16'hFFFF, b: 16'd1,    c: 16'd0,    x: 16'hFFFF, exp_res: 16'hFFFE};
    vecs[6] = '{req: 2'b11, exp_gnt: 2'b10, a: 16'd4,    b: 16'd5,    c: 16'd6,    x: 16'd7,    exp_res: 16'd237};
    vecs[7] = '{req: 2'b00, exp_gnt: 2'b01, a: 16'd1,    b: 16'd0,    c: 16'd0,    x: 16'd9,    exp_res: 16'd81};
    vecs[8] = '{req: 2'b10, exp_gnt: 2'b10, a: 16'd0,    b: 16'd0,    c: 16'hABCD, x: 16'h1234, exp_res: 16'hABCD};
    vecs[9] = '{req: 2'b01, exp_gnt: 2'b01, a: 16'd2,    b: 16'd0,    c: 16'd0,    x: 16'd2,    exp_res: 16'd8};

    for (int i = 0; i < 2; i++) begin
      bank_a[i] = '0; bank_b[i] = '0; bank_c[i] = '0; bank_x[i] = '0;
    end

    #3 check("reset_outs", outs_now(), 32'h0);
    @(negedge ck);
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    check("post_reset_outs", outs_now(), 32'h0);

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Reset during MUL2: async clear, no response, pointer back to requester 0.
    @(negedge ck);
    bank_a[0] = 16'd9; bank_b[0] = 16'd0; bank_c[0] = 16'd0; bank_x[0] = 16'd9;
    req = 2'b01;
    cyc = 0;
    do begin @(negedge ck); cyc++; end while (gnt == 2'b00 && cyc < 10);
    check("abort_gnt", gnt, 2'b01);
    req = 2'b00;
    repeat (3) @(negedge ck);
    check("abort_mul2_word", word_now(), exp_word[3]);
    #2 rst = 1'b0;
    #1 check("abort_async_outs", outs_now(), 32'h0);
    @(negedge ck);
    rst = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge ck);
      if (res_vld != 2'b00 || busy) seen = 1'b1;
    end
    check("abort_quiet", seen, 1'b0);
    v = '{req: 2'b11, exp_gnt: 2'b01, a: 16'd1, b: 16'd2, c: 16'd3, x: 16'd4, exp_res: 16'd27};
    run_txn(v);
    v = '{req: 2'b00, exp_gnt: 2'b10, a: 16'd5, b: 16'd0, c: 16'd1, x: 16'd1, exp_res: 16'd6};
    run_txn(v);

    // done while IDLE is ignored.
    @(negedge ck);
    done_force = 1'b1;
    @(negedge ck);
    done_force = 1'b0;
    check("stray_done_busy", busy, 1'b0);
    check("stray_done_vld", res_vld, 2'b00);

    // done never arrives from the datapath.
    done_en = 1'b0;
    @(negedge ck);
    bank_a[0] = 16'd1; bank_b[0] = 16'd1; bank_c[0] = 16'd1; bank_x[0] = 16'd1;
    req = 2'b01;
    cyc = 0;
    do begin @(negedge ck); cyc++; end while (gnt == 2'b00 && cyc < 10);
    check("hold_gnt", gnt, 2'b01);
    req = 2'b00;
`ifdef ESCALONADOR_TIMEOUT_EN
    cyc = 0;
    do begin @(negedge ck); cyc++; end while (res_vld == 2'b00 && cyc < 40);
    check("timeout_latency", cyc, 20);
    check("timeout_vld", res_vld, 2'b01);
    check("timeout_erro", erro, 1'b1);
    check("timeout_data", res_data, 16'h0000);
    @(negedge ck);
    check("timeout_erro_held", erro, 1'b1);
    check("timeout_idle", busy, 1'b0);
`else
    seen = 1'b0;
    repeat (30) begin
      @(negedge ck);
      if (res_vld != 2'b00) seen = 1'b1;
    end
    check("hold_no_vld", seen, 1'b0);
    check("hold_busy", busy, 1'b1);
    check("hold_erro", erro, 1'b0);
    done_force = 1'b1;
    @(negedge ck);
    done_force = 1'b0;
    check("hold_vld", res_vld, 2'b01);
    check("hold_data", res_data, 16'd3);
`endif
    done_en = 1'b1;

    // Pointer advanced past requester 0; erro cleared on the new grant.
    v = '{req: 2'b11, exp_gnt: 2'b10, a: 16'h0010, b: 16'h0002, c: 16'h0003, x: 16'h0010, exp_res: 16'h1023};
    run_txn(v);
    v = '{req: 2'b00, exp_gnt: 2'b01, a: 16'd0, b: 16'd0, c: 16'h5555, x: 16'd0, exp_res: 16'h5555};
    run_txn(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
